// File: rtl/fetch_queue_unit.sv
// Generic circular FIFO with synchronous clear; head is presented from registered storage.
// Latency: a write is visible at rd_dat the cycle after it is accepted; clear takes effect next cycle.
// Backpressure: rd_rdy pops the head when rd_vld; the caller must not write when count == DEPTH.
module fq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld & rd_rdy;
    // Empty reads return zero so the head fields are defined out of reset.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_vld && !clr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_vld, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Sequential instruction fetch with one outstanding memory request, buffering {pc, inst} for decode.
// Latency: request issues the cycle after a slot frees; acked data is visible at out_* one cycle later.
// Backpressure: out_ready stalls decode; fetch stops issuing once the queue would be full.
module fetch_queue_unit #(
    parameter int               XLEN     = 32,
    parameter int               ILEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [ILEN-1:0]          imem_rdata,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    entry_t          push_dat;
    entry_t          head_dat;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [CW-1:0]   occ_next;
    logic            discard;
    logic            ack_acc;
    logic            push;
    logic            pop;
    logic            req_free;
    logic            issue;

    // An ack only counts against a live request; stray acks after reset are ignored.
    assign ack_acc  = imem_req & imem_ack;
    assign push     = ack_acc & ~discard & ~redirect;
    assign pop      = out_valid & out_ready & ~redirect;
    assign req_free = ~imem_req | ack_acc;
    assign push_dat = {imem_addr, imem_rdata};

    always_comb begin
        occ_next = occupancy;
        if (redirect) begin
            occ_next = '0;
        end else if (push && !pop) begin
            occ_next = occupancy + 1'b1;
        end else if (pop && !push) begin
            occ_next = occupancy - 1'b1;
        end
    end

    assign issue = req_free & (occ_next < CW'(DEPTH)) & ~redirect;

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = redirect_pc & ~XLEN'(3);
        end else if (push) begin
            fetch_pc_next = imem_addr + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            discard   <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_next;
            // Address and request hold while a request waits for its ack.
            if (req_free) begin
                imem_req  <= issue;
                imem_addr <= fetch_pc_next;
            end
            if (ack_acc) begin
                discard <= 1'b0;
            end else if (redirect && imem_req) begin
                discard <= 1'b1;
            end
        end
    end

    fq_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (redirect),
        .wr_vld (push),
        .wr_dat (push_dat),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head_dat),
        .count  (occupancy)
    );

    assign out_pc   = head_dat.pc;
    assign out_inst = head_dat.inst;
endmodule
